mem_fetch: RTL

Instruction-fetch initiator that drives the request side of the memory's valid/ready command handshake and accepts its res_valid/res_ready response. It sequentially reads words from a fetch PC and buffers {pc, word} pairs in a small FIFO toward decode. It also handles PC redirects, which flush the FIFO and discard any in-flight response. Sits between the memory model and the core front end.

---
 rtl/mem_fetch_pkg.sv | 12 +
 rtl/mem_fetch_fifo.sv | 51 +++++
 rtl/mem_fetch.sv | 119 +++++++++++
 3 files changed

// File: rtl/mem_fetch_pkg.sv
// Shared definitions for the fetch initiator and the memory model: bus widths
// and the command encoding both sides of the request handshake agree on.
package mem_fetch_pkg;

  localparam int ADDRESS_WIDTH = 32;
  localparam int DATA_WIDTH    = 32;

  localparam int                       MEM_CMD_WIDTH = 2;
  localparam logic [MEM_CMD_WIDTH-1:0] MEM_CMD_READ  = 2'd0;
  localparam logic [MEM_CMD_WIDTH-1:0] MEM_CMD_WRITE = 2'd1;

endpackage

// File: rtl/mem_fetch_fifo.sv
// Small synchronous FIFO holding {pc, word} pairs between fetch and decode.
// Pointers wrap naturally at DEPTH (a power of two); flush empties it in one edge.
module mem_fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; stale contents are never visible because count gates them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/mem_fetch.sv
// Instruction-fetch initiator: one outstanding read at a time, sequential PC,
// responses buffered as {pc, word}; redirects flush and drop any in-flight reply.
module mem_fetch
  import mem_fetch_pkg::*;
#(
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC   = '0,
  parameter int                       FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDRESS_WIDTH-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0]    o_mem_data,
  output logic [MEM_CMD_WIDTH-1:0] o_mem_cmd,
  output logic                     o_mem_valid,
  input  logic                     i_mem_ready,
  input  logic [DATA_WIDTH-1:0]    i_mem_data,
  input  logic                     i_mem_res_valid,
  output logic                     o_mem_res_ready,
  input  logic                     i_redirect,
  input  logic [ADDRESS_WIDTH-1:0] i_redirect_pc,
  output logic                     o_valid,
  output logic [DATA_WIDTH-1:0]    o_instr,
  output logic [ADDRESS_WIDTH-1:0] o_pc,
  input  logic                     i_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = ADDRESS_WIDTH + DATA_WIDTH;

  typedef enum logic {
    S_ISSUE = 1'b0,
    S_WAIT  = 1'b1
  } state_t;

  state_t                   state, state_next;
  logic                     drop, drop_next;
  logic [ADDRESS_WIDTH-1:0] fetch_pc, fetch_pc_next;

  logic             req_accept, res_accept;
  logic             push, pop;
  logic [ENT_W-1:0] head;
  logic [CNT_W-1:0] count;
  logic             empty, full;

  assign o_mem_address   = fetch_pc;
  assign o_mem_data      = '0;
  assign o_mem_cmd       = MEM_CMD_READ;
  assign o_mem_valid     = (state == S_ISSUE) && (count < CNT_W'(FIFO_DEPTH));
  assign o_mem_res_ready = (state == S_WAIT);
  assign o_valid         = !empty;
  assign o_pc            = head[ENT_W-1:DATA_WIDTH];
  assign o_instr         = head[DATA_WIDTH-1:0];

  assign req_accept = o_mem_valid && i_mem_ready;
  assign res_accept = i_mem_res_valid && o_mem_res_ready;

  // Redirect outranks both FIFO operations; the flush clears everything anyway.
  assign push = res_accept && !drop && !i_redirect && !full;
  assign pop  = o_valid && i_ready && !i_redirect;

  always_comb begin
    state_next    = state;
    drop_next     = drop;
    fetch_pc_next = fetch_pc;
    case (state)
      S_ISSUE: begin
        drop_next = 1'b0;
        if (req_accept) begin
          state_next = S_WAIT;
          drop_next  = i_redirect;
        end
      end
      S_WAIT: begin
        if (res_accept) begin
          state_next = S_ISSUE;
          drop_next  = 1'b0;
          if (!drop && !i_redirect)
            fetch_pc_next = fetch_pc + ADDRESS_WIDTH'(DATA_WIDTH / 8);
        end else if (i_redirect) begin
          drop_next = 1'b1;
        end
      end
      default: begin
        state_next = S_ISSUE;
        drop_next  = 1'b0;
      end
    endcase
    if (i_redirect) fetch_pc_next = i_redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_ISSUE;
      drop     <= 1'b0;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_next;
      drop     <= drop_next;
      fetch_pc <= fetch_pc_next;
    end
  end

  mem_fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (i_redirect),
    .wdata ({fetch_pc, i_mem_data}),
    .rdata (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

endmodule
